spi_xfer_ctrl: RTL and testbench

SPI master transfer controller that sequences one 8-bit full-duplex SPI transaction per `start` request. It generates SCLK from the system clock via a programmable half-period divider and drives slave select and MOSI. It samples MISO and maintains the 3-bit bit index with the same CPOL/CPHA/LSBFE semantics as the SPI bit counter. It sits between the register/host interface and the SPI pins, and it also owns bit-index sequencing.

---
 rtl/spi_xfer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer controller: one full-duplex DATA_W-bit transaction per start request,
// with SCLK from a programmable half-period divider and CPOL/CPHA/LSB-first bit sequencing.
module spi_xfer_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [DATA_W-1:0]         tx_data_i,
  input  logic [DIV_W-1:0]          baud_div_i,
  input  logic                      cpol_i,
  input  logic                      cpha_i,
  input  logic                      lsbfe_i,
  input  logic                      miso_i,
  output logic                      sclk_o,
  output logic                      mosi_o,
  output logic                      ss_n_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [DATA_W-1:0]         rx_data_o,
  output logic [$clog2(DATA_W)-1:0] bit_idx_o
);

  localparam int unsigned IdxW  = $clog2(DATA_W);
  localparam int unsigned EdgeW = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StAssert,
    StShift,
    StHold,
    StDone
  } state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [EdgeW-1:0]  edge_q;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              cpha_q;
  logic              lsbfe_q;

  logic              sclk_q;
  logic              mosi_q;
  logic              ss_n_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rx_data_q;

  logic              tick;
  logic              leading;
  logic              last_edge;
  logic [IdxW-1:0]   idx_step;
  logic [IdxW-1:0]   idx_preset;

  always_comb begin
    tick       = (cnt_q == div_q);
    // edge_q counts completed edges, so an even count means the next edge is a leading one
    leading    = ~edge_q[0];
    last_edge  = (edge_q == EdgeW'(2 * DATA_W - 1));
    idx_step   = lsbfe_q ? (idx_q + IdxW'(1)) : (idx_q - IdxW'(1));
    idx_preset = lsbfe_i ? '0 : IdxW'(DATA_W - 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      div_q     <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      idx_q     <= idx_preset;
      tx_q      <= '0;
      rx_q      <= '0;
      cpha_q    <= 1'b0;
      lsbfe_q   <= 1'b0;
      sclk_q    <= cpol_i;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sclk_q <= cpol_i;
          ss_n_q <= 1'b1;
          mosi_q <= 1'b0;
          idx_q  <= idx_preset;
          if (start_i) begin
            tx_q    <= tx_data_i;
            div_q   <= baud_div_i;
            cpha_q  <= cpha_i;
            lsbfe_q <= lsbfe_i;
            rx_q    <= '0;
            cnt_q   <= '0;
            edge_q  <= '0;
            busy_q  <= 1'b1;
            ss_n_q  <= 1'b0;
            // CPHA=0 needs the first bit on the wire before the first leading edge
            mosi_q  <= cpha_i ? 1'b0 : tx_data_i[idx_preset];
            state_q <= StAssert;
          end
        end

        StAssert: begin
          if (tick) begin
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end

        StShift: begin
          if (!tick) begin
            cnt_q <= cnt_q + DIV_W'(1);
          end else begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + EdgeW'(1);
            if (leading) begin
              if (!cpha_q) begin
                rx_q[idx_q] <= miso_i;
              end else begin
                mosi_q <= tx_q[idx_q];
              end
            end else begin
              if (cpha_q) begin
                rx_q[idx_q] <= miso_i;
              end
              if (!last_edge) begin
                idx_q <= idx_step;
                if (!cpha_q) begin
                  mosi_q <= tx_q[idx_step];
                end
              end
            end
            if (last_edge) begin
              state_q <= StHold;
            end
          end
        end

        StHold: begin
          if (tick) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            done_q    <= 1'b1;
            mosi_q    <= 1'b0;
            rx_data_q <= rx_q;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign ss_n_o    = ss_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign bit_idx_o = idx_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: a cycle-level observer plus an arithmetic SPI reference.
module tb_spi_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] baud_div;
  logic       cpol, cpha, lsbfe;
  logic       miso;
  logic       sclk, mosi, ss_n, busy, done;
  logic [7:0] rx_data;
  logic [2:0] bit_idx;

  int checks = 0;
  int errors = 0;

  // slave model state: loopback or a fixed response byte in the configured bit order
  logic       m_loop = 1'b1;
  logic       m_lsb  = 1'b0;
  logic [7:0] m_resp = 8'h00;
  logic [3:0] samp_k = 4'd0;
  logic [2:0] ridx;

  // observation results of the last run_xfer
  int         o_busy, o_done_cnt, o_done_cyc, o_rises, o_sclk_err, o_ss_err, o_nlead, o_nsamp;
  logic [7:0] o_rx, o_mosi, o_seq;
  logic [2:0] o_idx [8];

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.DATA_W(8), .DIV_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .tx_data_i  (tx_data),
    .baud_div_i (baud_div),
    .cpol_i     (cpol),
    .cpha_i     (cpha),
    .lsbfe_i    (lsbfe),
    .miso_i     (miso),
    .sclk_o     (sclk),
    .mosi_o     (mosi),
    .ss_n_o     (ss_n),
    .busy_o     (busy),
    .done_o     (done),
    .rx_data_o  (rx_data),
    .bit_idx_o  (bit_idx)
  );

  always_comb begin
    ridx = m_lsb ? samp_k[2:0] : (3'd7 - samp_k[2:0]);
    miso = m_loop ? mosi : m_resp[ridx];
  end

  // SCLK level in cycle c (1 = first busy cycle): edge k becomes visible in cycle (k+1)*h+1
  function automatic logic exp_sclk(input int c, input int h, input logic pol);
    int n;
    if (c - 1 < 2 * h) n = 0;
    else n = (c - 1 - h) / h;
    if (n > 16) n = 16;
    return pol ^ n[0];
  endfunction

  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] div, input logic pol,
                          input logic pha, input logic lsb, input logic lp, input logic [7:0] rsp,
                          input bit perturb, input bit start_shift, input bit start_done);
    int   h;
    logic prev;
    logic [2:0] ord;
    h = int'(div) + 1;
    m_loop = lp; m_resp = rsp; m_lsb = lsb; samp_k = 4'd0;
    o_busy = 0; o_done_cnt = 0; o_done_cyc = 0; o_rises = 0; o_sclk_err = 0; o_ss_err = 0;
    o_nlead = 0; o_nsamp = 0; o_rx = 8'h00; o_mosi = 8'h00; o_seq = 8'h00;
    for (int i = 0; i < 8; i++) o_idx[i] = 3'd0;
    @(posedge clk); #1;
    tx_data = tx; baud_div = div; cpol = pol; cpha = pha; lsbfe = lsb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev = pol;
    for (int c = 1; c <= 18 * h + 4; c++) begin
      @(negedge clk);
      if (busy === 1'b1) o_busy++;
      if (ss_n !== ((c <= 18 * h) ? 1'b0 : 1'b1)) o_ss_err++;
      if (c <= 18 * h + 1 && sclk !== exp_sclk(c, h, pol)) o_sclk_err++;
      if (sclk !== prev) begin
        if (sclk === ~pol) begin
          if (o_nlead < 8) o_idx[o_nlead] = bit_idx;
          o_nlead++;
        end
        if (sclk === (pha ? pol : ~pol)) begin
          ord = lsb ? samp_k[2:0] : (3'd7 - samp_k[2:0]);
          o_mosi[ord] = mosi;
          o_seq = {o_seq[6:0], mosi};
          samp_k = samp_k + 4'd1;
          o_nsamp++;
        end
        if (prev === 1'b0 && sclk === 1'b1) o_rises++;
      end
      prev = sclk;
      if (perturb && c == 4 * h) begin
        cpol = ~pol; lsbfe = ~lsb; cpha = ~pha; baud_div = div ^ 8'h05; tx_data = ~tx;
      end
      if (start_shift && c == 3 * h) start = 1'b1;
      if (start_shift && c == 3 * h + 1) start = 1'b0;
      if (done === 1'b1) begin
        o_done_cnt++;
        o_done_cyc = c;
        o_rx = rx_data;
        if (start_done) begin
          start = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cpol = 1'b1; lsbfe = 1'b0; cpha = 1'b0;
    tx_data = 8'h00; baud_div = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", sclk); end
    checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %b want 1", ss_n); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    checks++; if (bit_idx !== 3'd7) begin errors++; $display("FAIL reset_idx_msb: got %0d want 7", bit_idx); end
    cpol = 1'b0; lsbfe = 1'b1;
    @(negedge clk);
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk_live: got %b want 0", sclk); end
    checks++; if (bit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx_lsb: got %0d want 0", bit_idx); end
    rst = 1'b0; cpol = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL idle_sclk_track: got %b want 1", sclk); end
  endtask

  task automatic test_mode0;
    run_xfer(8'hA5, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (o_busy != 18) begin errors++; $display("FAIL m0_busy: got %0d want 18", o_busy); end
    checks++; if (o_done_cyc != 19) begin errors++; $display("FAIL m0_done_cyc: got %0d want 19", o_done_cyc); end
    checks++; if (o_rx !== 8'hA5) begin errors++; $display("FAIL m0_rx: got %h want a5", o_rx); end
    checks++; if (o_rises != 8) begin errors++; $display("FAIL m0_rises: got %0d want 8", o_rises); end
    checks++; if (o_seq !== 8'b1010_0101) begin errors++; $display("FAIL m0_mosi_seq: got %b want 10100101", o_seq); end
    checks++; if (o_sclk_err != 0) begin errors++; $display("FAIL m0_sclk_wave: got %0d bad cycles want 0", o_sclk_err); end
    checks++; if (o_ss_err != 0) begin errors++; $display("FAIL m0_ss_n: got %0d bad cycles want 0", o_ss_err); end
  endtask

  task automatic test_mode3;
    run_xfer(8'h3C, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
    checks++; if (o_busy != 72) begin errors++; $display("FAIL m3_busy: got %0d want 72", o_busy); end
    checks++; if (o_done_cyc != 73) begin errors++; $display("FAIL m3_done_cyc: got %0d want 73", o_done_cyc); end
    checks++; if (o_rx !== 8'h96) begin errors++; $display("FAIL m3_rx: got %h want 96", o_rx); end
    checks++; if (o_mosi !== 8'h3C) begin errors++; $display("FAIL m3_mosi: got %h want 3c", o_mosi); end
    checks++; if (o_sclk_err != 0) begin errors++; $display("FAIL m3_sclk_wave: got %0d bad cycles want 0", o_sclk_err); end
    checks++; if (o_nlead != 8) begin errors++; $display("FAIL m3_nlead: got %0d want 8", o_nlead); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (o_idx[k] !== 3'(k)) begin
        errors++; $display("FAIL m3_bit_idx[%0d]: got %0d want %0d", k, o_idx[k], k);
      end
    end
    @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL m3_idle_sclk: got %b want 1", sclk); end
  endtask

  task automatic test_modes12;
    logic pol;
    logic [7:0] div;
    for (int m = 1; m <= 2; m++) begin
      pol = (m == 2);
      div = 8'($urandom_range(0, 3));
      run_xfer(8'h81, div, pol, ~pol, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (o_rx !== 8'h81) begin errors++; $display("FAIL m%0d_rx: got %h want 81", m, o_rx); end
      checks++; if (o_sclk_err != 0) begin errors++; $display("FAIL m%0d_sclk_wave: got %0d want 0", m, o_sclk_err); end
      checks++;
      if (o_busy != 18 * (int'(div) + 1)) begin
        errors++; $display("FAIL m%0d_busy: got %0d want %0d", m, o_busy, 18 * (int'(div) + 1));
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (o_idx[k] !== 3'(7 - k)) begin
          errors++; $display("FAIL m%0d_bit_idx[%0d]: got %0d want %0d", m, k, o_idx[k], 7 - k);
        end
      end
      @(negedge clk);
      checks++; if (sclk !== pol) begin errors++; $display("FAIL m%0d_idle_sclk: got %b want %b", m, sclk, pol); end
    end
  endtask

  task automatic test_back_to_back;
    int got;
    run_xfer(8'h6B, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    checks++; if (o_done_cnt != 1) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 1", o_done_cnt); end
    checks++; if (o_busy != 36) begin errors++; $display("FAIL b2b_busy: got %0d want 36", o_busy); end
    checks++; if (o_rx !== 8'h6B) begin errors++; $display("FAIL b2b_rx1: got %h want 6b", o_rx); end
    // start is high in the DONE cycle and the next one; only the latter may be accepted
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_ignored: got busy %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0; tx_data = 8'hD2;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b want 1", busy); end
    got = 0;
    for (int c = 2; c <= 50; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = c;
        break;
      end
    end
    checks++; if (got != 37) begin errors++; $display("FAIL b2b_done2_cyc: got %0d want 37", got); end
    checks++; if (rx_data !== 8'h6B) begin errors++; $display("FAIL b2b_rx2: got %h want 6b", rx_data); end
  endtask

  task automatic test_mid_reset;
    int dcount;
    run_xfer(8'h5A, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (o_rx !== 8'h5A) begin errors++; $display("FAIL mr_pre_rx: got %h want 5a", o_rx); end
    @(posedge clk); #1;
    tx_data = 8'hC3; baud_div = 8'd1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL mr_after5_sclk: got %b want 1", sclk); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL mr_ss_n: got %b want 1", ss_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mr_rx: got %h want 00", rx_data); end
    dcount = 0;
    for (int c = 0; c < 50; c++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    checks++; if (dcount != 0) begin errors++; $display("FAIL mr_no_done: got %0d want 0", dcount); end
    run_xfer(8'hE7, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0, 1'b0);
    checks++; if (o_rx !== 8'h4D) begin errors++; $display("FAIL mr_post_rx: got %h want 4d", o_rx); end
    checks++; if (o_done_cyc != 55) begin errors++; $display("FAIL mr_post_done: got %0d want 55", o_done_cyc); end
  endtask

  task automatic test_perturb;
    logic [7:0] tx, rsp;
    logic pha;
    tx = 8'($urandom); rsp = 8'($urandom); pha = 1'($urandom);
    run_xfer(tx, 8'd2, 1'b0, pha, 1'b0, 1'b0, rsp, 1'b1, 1'b0, 1'b0);
    checks++; if (o_rx !== rsp) begin errors++; $display("FAIL pt_rx: got %h want %h", o_rx, rsp); end
    checks++; if (o_mosi !== tx) begin errors++; $display("FAIL pt_mosi: got %h want %h", o_mosi, tx); end
    checks++; if (o_sclk_err != 0) begin errors++; $display("FAIL pt_sclk_wave: got %0d want 0", o_sclk_err); end
    checks++; if (o_ss_err != 0) begin errors++; $display("FAIL pt_ss_n: got %0d want 0", o_ss_err); end
    checks++; if (o_done_cyc != 55) begin errors++; $display("FAIL pt_done_cyc: got %0d want 55", o_done_cyc); end
  endtask

  task automatic test_random;
    logic [7:0] tx, rsp, div, exp_rx;
    logic pol, pha, lsb, lp;
    int h;
    for (int n = 0; n < 8; n++) begin
      tx = 8'($urandom); rsp = 8'($urandom); div = 8'($urandom_range(0, 5));
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom); lp = 1'($urandom);
      h = int'(div) + 1;
      exp_rx = lp ? tx : rsp;
      run_xfer(tx, div, pol, pha, lsb, lp, rsp, 1'b0, 1'b0, 1'b0);
      checks++; if (o_rx !== exp_rx) begin errors++; $display("FAIL rnd%0d_rx: got %h want %h", n, o_rx, exp_rx); end
      checks++; if (o_mosi !== tx) begin errors++; $display("FAIL rnd%0d_mosi: got %h want %h", n, o_mosi, tx); end
      checks++; if (o_busy != 18 * h) begin errors++; $display("FAIL rnd%0d_busy: got %0d want %0d", n, o_busy, 18 * h); end
      checks++; if (o_done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done_cnt: got %0d want 1", n, o_done_cnt); end
      checks++; if (o_sclk_err != 0) begin errors++; $display("FAIL rnd%0d_sclk_wave: got %0d want 0", n, o_sclk_err); end
      checks++; if (o_ss_err != 0) begin errors++; $display("FAIL rnd%0d_ss_n: got %0d want 0", n, o_ss_err); end
      checks++; if (o_nsamp != 8) begin errors++; $display("FAIL rnd%0d_nsamp: got %0d want 8", n, o_nsamp); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_modes12();
    test_back_to_back();
    test_mid_reset();
    test_perturb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation timeout");
  end

endmodule
